// File: rtl/iob_cache_req_arbiter_pkg.sv
// Shared definitions for the cache request arbiter and its ID FIFO.
package iob_cache_req_arbiter_pkg;

  localparam int unsigned DefaultAddrW = 32;
  localparam int unsigned DefaultDataW = 32;

  // Master ID width: at least one bit, even for a single requester.
  function automatic int unsigned id_width(input int unsigned n_masters);
    return (n_masters <= 2) ? 1 : $clog2(n_masters);
  endfunction

endpackage

// File: rtl/iob_cache_req_arbiter_if.sv
// IOb request/response bundle, NPorts lanes packed side by side.
interface iob_cache_req_arbiter_if #(
  parameter int unsigned NPorts = 1,
  parameter int unsigned AddrW  = 32,
  parameter int unsigned DataW  = 32
);

  logic [NPorts-1:0]         valid;
  logic [NPorts*AddrW-1:0]   addr;
  logic [NPorts*DataW-1:0]   wdata;
  logic [NPorts*DataW/8-1:0] wstrb;
  logic [NPorts-1:0]         ready;
  logic [NPorts-1:0]         rvalid;
  logic [NPorts*DataW-1:0]   rdata;

  // Requester side: issues requests, receives handshake and read data.
  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rvalid, rdata
  );

  // Responder side: accepts requests, returns handshake and read data.
  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/iob_cache_arb_id_fifo.sv
// Small FIFO holding the master ID of every outstanding read, oldest at the head.
module iob_cache_arb_id_fifo #(
  parameter int unsigned W     = 1,
  parameter int unsigned Depth = 2
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         cke_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [W-1:0]    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            push_en, pop_en;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  // Pointer and occupancy next state; pointers wrap because Depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_en && !pop_en)      cnt_d = cnt_q + 1'b1;
    else if (!push_en && pop_en) cnt_d = cnt_q - 1'b1;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (cke_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (cke_i && push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/iob_cache_req_arbiter.sv
// Round-robin arbiter sharing the cache front-end IOb port between NMasters requesters.
// Read responses are routed back to their issuer via an ID FIFO.
module iob_cache_req_arbiter
  import iob_cache_req_arbiter_pkg::*;
#(
  parameter int unsigned NMasters  = 2,
  parameter int unsigned AddrW     = DefaultAddrW,
  parameter int unsigned DataW     = DefaultDataW,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_i,
  iob_cache_req_arbiter_if.slave  m_iob,
  iob_cache_req_arbiter_if.master s_iob,
  output logic                    err_o
);

  localparam int unsigned IdW   = id_width(NMasters);
  localparam int unsigned StrbW = DataW / 8;

  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0] lock_id_q, lock_id_d;
  logic           lock_q, lock_d;
  logic           err_q, err_d;
  logic [IdW-1:0] win_id, cand_id, head_id;
  int unsigned    cand;
  logic           any_win, s_valid, accept, push, pop;
  logic           fifo_full, fifo_empty;

  // Winner: held grant while locked, else first valid master from rr_ptr upward.
  always_comb begin
    any_win = 1'b0;
    win_id  = '0;
    cand    = 0;
    cand_id = '0;
    if (lock_q) begin
      win_id  = lock_id_q;
      any_win = m_iob.valid[lock_id_q];
    end else begin
      for (int unsigned k = 0; k < NMasters; k++) begin
        cand = 32'(rr_ptr_q) + k;
        if (cand >= NMasters) cand = cand - NMasters;
        cand_id = cand[IdW-1:0];
        if (!any_win && m_iob.valid[cand_id]) begin
          any_win = 1'b1;
          win_id  = cand_id;
        end
      end
    end
  end

  // A full FIFO blocks every new request, even when a pop is under way.
  assign s_valid = any_win & ~fifo_full;
  assign accept  = s_valid & s_iob.ready[0];
  assign push    = accept & (s_iob.wstrb == '0);
  assign pop     = s_iob.rvalid[0] & ~fifo_empty;

  // Forward the winner's request and steer handshake/response back per master.
  always_comb begin
    s_iob.valid   = s_valid;
    s_iob.addr    = '0;
    s_iob.wdata   = '0;
    s_iob.wstrb   = '0;
    m_iob.ready   = '0;
    m_iob.rvalid  = '0;
    m_iob.rdata   = {NMasters{s_iob.rdata}};
    for (int unsigned i = 0; i < NMasters; i++) begin
      if (any_win && win_id == IdW'(i)) begin
        s_iob.addr  = m_iob.addr[i*AddrW +: AddrW];
        s_iob.wdata = m_iob.wdata[i*DataW +: DataW];
        s_iob.wstrb = m_iob.wstrb[i*StrbW +: StrbW];
        m_iob.ready[i] = s_iob.ready[0] & s_valid;
      end
      if (pop && head_id == IdW'(i)) m_iob.rvalid[i] = 1'b1;
    end
  end

  // Round-robin pointer, grant lock and sticky error next state.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (s_iob.rvalid[0] & fifo_empty);
    if (accept) begin
      lock_d = 1'b0;
      if (win_id == IdW'(NMasters - 1)) rr_ptr_d = '0;
      else                              rr_ptr_d = win_id + 1'b1;
    end else if (s_valid) begin
      lock_d    = 1'b1;
      lock_id_d = win_id;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else if (cke_i) begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;

  iob_cache_arb_id_fifo #(
    .W     (IdW),
    .Depth (FifoDepth)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .cke_i   (cke_i),
    .push_i  (push),
    .data_i  (win_id),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_iob_cache_req_arbiter.sv
// Bench for iob_cache_req_arbiter: directed vector table, hand-written corner sequences and
// random traffic checked against a queue-based reference model.
module tb_iob_cache_req_arbiter;

  localparam int unsigned N     = 2;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  logic        clk, cke, arst;
  logic [1:0]  valid;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  wstrb0, wstrb1;
  logic        s_ready, s_rvalid;
  logic [31:0] s_rdata;
  logic        err;

  iob_cache_req_arbiter_if #(.NPorts(N), .AddrW(AW), .DataW(DW)) m_bus ();
  iob_cache_req_arbiter_if #(.NPorts(1), .AddrW(AW), .DataW(DW)) s_bus ();

  assign m_bus.valid  = valid;
  assign m_bus.addr   = {addr1, addr0};
  assign m_bus.wdata  = {wdata1, wdata0};
  assign m_bus.wstrb  = {wstrb1, wstrb0};
  assign s_bus.ready  = s_ready;
  assign s_bus.rvalid = s_rvalid;
  assign s_bus.rdata  = s_rdata;

  iob_cache_req_arbiter #(
    .NMasters  (N),
    .AddrW     (AW),
    .DataW     (DW),
    .FifoDepth (DEPTH)
  ) dut (
    .clk_i  (clk),
    .cke_i  (cke),
    .arst_i (arst),
    .m_iob  (m_bus),
    .s_iob  (s_bus),
    .err_o  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: next-priority master, held (stalled) grant, queue of read owners.
  int prio;
  int held;
  int q[$];
  bit err_m;
  int m_win;

  logic        exp_sv;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [1:0]  exp_ready, exp_rvalid;
  logic        exp_err;

  function automatic logic vbit(input int i);
    return (i == 0) ? valid[0] : valid[1];
  endfunction

  task automatic model_reset();
    prio  = 0;
    held  = -1;
    q.delete();
    err_m = 1'b0;
  endtask

  task automatic model_eval();
    int w;
    int i;
    w = -1;
    if (held >= 0) begin
      if (vbit(held)) w = held;
    end else begin
      for (int k = 0; k < N; k++) begin
        i = (prio + k) % N;
        if (w < 0 && vbit(i)) w = i;
      end
    end
    m_win      = w;
    exp_sv     = (w >= 0) && (q.size() < DEPTH);
    exp_addr   = (w == 0) ? addr0  : (w == 1) ? addr1  : 32'h0;
    exp_wdata  = (w == 0) ? wdata0 : (w == 1) ? wdata1 : 32'h0;
    exp_wstrb  = (w == 0) ? wstrb0 : (w == 1) ? wstrb1 : 4'h0;
    exp_ready  = 2'b00;
    if (exp_sv && s_ready) exp_ready = (w == 0) ? 2'b01 : 2'b10;
    exp_rvalid = 2'b00;
    if (s_rvalid && q.size() > 0) exp_rvalid = (q[0] == 0) ? 2'b01 : 2'b10;
    exp_err    = err_m;
  endtask

  task automatic model_commit();
    bit pop_ok;
    if (arst || !cke) return;
    pop_ok = s_rvalid && (q.size() > 0);
    if (s_rvalid && !pop_ok) err_m = 1'b1;
    if (pop_ok) void'(q.pop_front());
    if (exp_sv && s_ready) begin
      prio = (m_win + 1) % N;
      held = -1;
      if (exp_wstrb == 4'h0) q.push_back(m_win);
    end else if (exp_sv) begin
      held = m_win;
    end
  endtask

  task automatic check_bits(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string name);
    logic [137:0] act, exp;
    act = {s_bus.valid, s_bus.addr, s_bus.wdata, s_bus.wstrb, m_bus.ready, m_bus.rvalid,
           m_bus.rdata, err};
    exp = {exp_sv, exp_addr, exp_wdata, exp_wstrb, exp_ready, exp_rvalid,
           s_rdata, s_rdata, exp_err};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic eval_check(input string name);
    if (arst) model_reset();
    #1;
    model_eval();
    check_all(name);
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid = 2'b00; wstrb0 = 4'h0; wstrb1 = 4'h0;
    s_ready = 1'b1; s_rvalid = 1'b0; cke = 1'b1; arst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [3:0]  wstrb1;
    logic        s_ready;
    logic        s_rvalid;
    logic        exp_sv;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rvalid;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];
  logic [41:0] t_act, t_exp;

  initial begin
    idle_inputs();
    addr0 = 32'h100; addr1 = 32'h40; wdata0 = 32'hA0; wdata1 = 32'hB0; s_rdata = 32'h0;
    arst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;

    // valid, wstrb1, s_ready, s_rvalid | sv, addr, wstrb, ready, rvalid, err
    tbl.push_back('{2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 32'h000, 4'h0, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b11, 4'h0, 1'b1, 1'b0, 1'b1, 32'h100, 4'h0, 2'b01, 2'b00, 1'b0});
    tbl.push_back('{2'b11, 4'h0, 1'b1, 1'b1, 1'b1, 32'h040, 4'h0, 2'b10, 2'b01, 1'b0});
    tbl.push_back('{2'b11, 4'h0, 1'b1, 1'b1, 1'b1, 32'h100, 4'h0, 2'b01, 2'b10, 1'b0});
    tbl.push_back('{2'b11, 4'h0, 1'b1, 1'b1, 1'b1, 32'h040, 4'h0, 2'b10, 2'b01, 1'b0});
    tbl.push_back('{2'b00, 4'h0, 1'b1, 1'b1, 1'b0, 32'h000, 4'h0, 2'b00, 2'b10, 1'b0});
    tbl.push_back('{2'b01, 4'h0, 1'b1, 1'b0, 1'b1, 32'h100, 4'h0, 2'b01, 2'b00, 1'b0});
    tbl.push_back('{2'b10, 4'h0, 1'b1, 1'b0, 1'b1, 32'h040, 4'h0, 2'b10, 2'b00, 1'b0});
    tbl.push_back('{2'b11, 4'h0, 1'b1, 1'b0, 1'b0, 32'h100, 4'h0, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b11, 4'h0, 1'b1, 1'b1, 1'b0, 32'h100, 4'h0, 2'b00, 2'b01, 1'b0});
    tbl.push_back('{2'b11, 4'h0, 1'b1, 1'b0, 1'b1, 32'h100, 4'h0, 2'b01, 2'b00, 1'b0});
    tbl.push_back('{2'b00, 4'h0, 1'b1, 1'b1, 1'b0, 32'h000, 4'h0, 2'b00, 2'b10, 1'b0});
    tbl.push_back('{2'b00, 4'h0, 1'b1, 1'b1, 1'b0, 32'h000, 4'h0, 2'b00, 2'b01, 1'b0});
    tbl.push_back('{2'b00, 4'h0, 1'b1, 1'b1, 1'b0, 32'h000, 4'h0, 2'b00, 2'b00, 1'b0});
    tbl.push_back('{2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 32'h000, 4'h0, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b10, 4'hF, 1'b0, 1'b0, 1'b1, 32'h040, 4'hF, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b11, 4'hF, 1'b0, 1'b0, 1'b1, 32'h040, 4'hF, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b11, 4'hF, 1'b0, 1'b0, 1'b1, 32'h040, 4'hF, 2'b00, 2'b00, 1'b1});
    tbl.push_back('{2'b11, 4'hF, 1'b1, 1'b0, 1'b1, 32'h040, 4'hF, 2'b10, 2'b00, 1'b1});
    tbl.push_back('{2'b11, 4'hF, 1'b1, 1'b0, 1'b1, 32'h100, 4'h0, 2'b01, 2'b00, 1'b1});
    tbl.push_back('{2'b00, 4'h0, 1'b1, 1'b1, 1'b0, 32'h000, 4'h0, 2'b00, 2'b01, 1'b1});

    foreach (tbl[r]) begin
      valid    = tbl[r].valid;
      wstrb1   = tbl[r].wstrb1;
      s_ready  = tbl[r].s_ready;
      s_rvalid = tbl[r].s_rvalid;
      s_rdata  = 32'h1000 + 32'(r);
      #1;
      model_eval();
      t_act = {s_bus.valid, s_bus.addr, s_bus.wstrb, m_bus.ready, m_bus.rvalid, err};
      t_exp = {tbl[r].exp_sv, tbl[r].exp_addr, tbl[r].exp_wstrb, tbl[r].exp_ready,
               tbl[r].exp_rvalid, tbl[r].exp_err};
      check_bits($sformatf("table[%0d]", r), 64'(t_act), 64'(t_exp));
      check_bits($sformatf("table[%0d].rdata", r), 64'(m_bus.rdata), {s_rdata, s_rdata});
      tick();
    end

    // Reset with a read outstanding: FIFO cleared, priority back to M0, late rvalid errors.
    idle_inputs();
    arst = 1'b1; eval_check("rst_pre"); tick();
    arst = 1'b0;
    valid = 2'b01; eval_check("rst_rd"); tick();
    valid = 2'b00; arst = 1'b1; eval_check("rst_pulse");
    check_bits("rst_err_clear", 64'(err), 64'h0);
    tick();
    arst = 1'b0; valid = 2'b11; s_ready = 1'b1;
    eval_check("rst_contend");
    check_bits("rst_grant_m0", 64'(m_bus.ready), 64'h1);
    tick();
    valid = 2'b00; s_rvalid = 1'b1;
    eval_check("rst_rv0");
    check_bits("rst_rv0_route", 64'(m_bus.rvalid), 64'h1);
    tick();
    eval_check("rst_rv_empty");
    check_bits("rst_rv_empty_none", 64'(m_bus.rvalid), 64'h0);
    tick();
    s_rvalid = 1'b0;
    eval_check("rst_err_set");
    check_bits("rst_err_sticky", 64'(err), 64'h1);
    tick();

    // Lock on M0 while rr_ptr points at M1, then freeze with cke low.
    idle_inputs();
    arst = 1'b1; eval_check("cke_rst"); tick();
    arst = 1'b0;
    valid = 2'b01; wstrb0 = 4'hF; eval_check("cke_acc_m0"); tick();
    s_ready = 1'b0; eval_check("cke_stall_m0"); tick();
    valid = 2'b11;
    eval_check("cke_locked");
    check_bits("cke_locked_addr", 64'(s_bus.addr), 64'h100);
    tick();
    cke = 1'b0; s_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      eval_check("cke_frozen");
      check_bits("cke_frozen_grant", 64'(m_bus.ready), 64'h1);
      tick();
    end
    cke = 1'b1;
    eval_check("cke_resume");
    check_bits("cke_resume_grant_m0", 64'(m_bus.ready), 64'h1);
    tick();
    eval_check("cke_next");
    check_bits("cke_next_grant_m1", 64'(m_bus.ready), 64'h2);
    tick();

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      valid    = 2'($urandom_range(0, 3));
      addr0    = $urandom; addr1 = $urandom;
      wdata0   = $urandom; wdata1 = $urandom;
      wstrb0   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      wstrb1   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      s_ready  = ($urandom_range(0, 3) != 0);
      s_rvalid = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      s_rdata  = $urandom;
      cke      = ($urandom_range(0, 9) != 0);
      arst     = ($urandom_range(0, 250) == 0);
      eval_check($sformatf("rand[%0d]", c));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/iob_cache_req_arbiter.md
# iob_cache_req_arbiter

Round-robin arbiter that shares the single IOb slave port of the cache front end between N_MASTERS IOb requesters, e.g. instruction and data ports of a CPU. It forwards one granted request per handshake downstream and holds the grant until the cache accepts it. It tracks the owner of every outstanding read in a small ID FIFO so that each `rvalid` returns to the master that issued it. It sits directly in front of `iob_cache_front_end`, inside the cache top level.

## Interface
- N_MASTERS, 2: number of requesters (≥2).
- ADDR_W, 32: address width (full front-end address, including the ctrl-select MSB).
- DATA_W, 32: data width.
- FIFO_DEPTH, 2: outstanding-read ID FIFO depth, power of 2, ≥2.
- clk_i  in  1  clock.
- cke_i  in  1  clock enable; all registers hold when low.
- arst_i  in  1  reset, asynchronous, active-high.
- m_iob_valid_i  in  N_MASTERS  per-master request valid.
- m_iob_addr_i  in  N_MASTERS*ADDR_W  master i occupies bits [i*ADDR_W +: ADDR_W].
- m_iob_wdata_i  in  N_MASTERS*DATA_W  write data, packed likewise.
- m_iob_wstrb_i  in  N_MASTERS*DATA_W/8  write strobes; all-zero means read.
- m_iob_ready_o  out  N_MASTERS  request accepted when valid & ready.
- m_iob_rvalid_o  out  N_MASTERS  read data valid, one-hot or zero.
- m_iob_rdata_o  out  N_MASTERS*DATA_W  s_iob_rdata_i replicated to every master.
- s_iob_valid_o, s_iob_addr_o (ADDR_W), s_iob_wdata_o (DATA_W), s_iob_wstrb_o (DATA_W/8)  out  forwarded request.
- s_iob_ready_i, s_iob_rvalid_i (1), s_iob_rdata_i (DATA_W)  in  cache response.
- err_o  out  1  sticky: rvalid received with ID FIFO empty.

## Operation
- ID_W = max(1, clog2(N_MASTERS)).
- Registers: `rr_ptr` (ID_W), `lock` (1), `lock_id` (ID_W), ID FIFO, `err_o`.
- Arbitration when `lock`=0:
  - Winner is the first valid master searching from `rr_ptr` upward, wrapping at N_MASTERS.
  - Combinational, same cycle.
- When `lock`=1, the winner is `lock_id`, regardless of other valids.
- Forwarding: `s_iob_valid_o = any_winner & ~fifo_full_block`; addr, wdata and wstrb are muxed from the winner. With no winner, all forwarded fields are 0.
- fifo_full_block = FIFO full. Accept is blocked when full, even if a pop occurs in the same cycle.
- Handshake: `m_iob_ready_o[w] = s_iob_ready_i & s_iob_valid_o`. All non-winners see ready 0.
- Accept (s_valid & s_ready):
  - `rr_ptr` ← (w+1) mod N_MASTERS.
  - `lock` ← 0.
  - If wstrb == 0 (read), push w into the ID FIFO.
- Stall (s_valid & ~s_ready): `lock` ← 1, `lock_id` ← w. Masters must hold their request, so the locked winner stays stable.
- Response routing:
  - On `s_iob_rvalid_i` with the FIFO non-empty, `m_iob_rvalid_o[head]` = 1 and the FIFO pops.
  - With the FIFO empty, no master rvalid is asserted and `err_o` ← 1 until reset.
- Simultaneous push and pop (FIFO not full) is allowed; the count is unchanged.
- Writes produce no rvalid and no FIFO entry.

## Timing
- Reset values: `rr_ptr`=0, `lock`=0, FIFO empty, `err_o`=0. All outputs are 0 when every m_iob_valid_i is 0.
- Request path is zero latency, combinational from m_iob_* to s_iob_* and from s_iob_ready_i to m_iob_ready_o.
- Response path is zero latency, combinational from s_iob_rvalid_i to m_iob_rvalid_o.
- Back-to-back accepts are possible every cycle. Round robin alternates when several masters are continuously valid.
- Reset asserted mid-transaction clears the FIFO and lock; later rvalids set `err_o`.
- cke_i=0 freezes all state. Combinational paths stay live.

## Structure
- ID_W and the packing/slicing macros go in the shared `iob_cache_conf.vh` header.
- The ID FIFO is one sub-module, `iob_cache_arb_id_fifo`:
  - Parameters W, DEPTH.
  - Ports: push/pop/data in/out, full, empty.
  - Reset empty; pointers wrap.
- The arbiter keeps arbitration and muxing in the top.

## Test plan
- M0 and M1 reads both valid each cycle, s_ready=1, rvalid 1 cycle later -> grants M0,M1,M0,M1; rvalids go to M0,M1,M0,M1 with the matching rdata.
- M1 write (wstrb=4'hF, addr 0x40) with s_ready=0 for 3 cycles while M0 raises valid in cycle 2 -> M1 stays forwarded and is accepted in cycle 4; M0 is granted in cycle 5; no FIFO push.
- FIFO filled with 2 reads and no rvalid -> s_iob_valid_o=0 and ready=0; one rvalid in that cycle is still blocked; accepting resumes next cycle.
- s_iob_rvalid_i pulse with FIFO empty -> no m_iob_rvalid_o, err_o=1 and it stays 1.
- arst_i pulsed with one read outstanding -> rr_ptr=0, FIFO empty; the next M0/M1 contention grants M0.
- cke_i=0 for 2 cycles during lock -> lock_id and rr_ptr unchanged; arbitration resumes correctly.
